// File: rtl/int_alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// int_alu_arbiter_if
// Bundles the requester bus, the shared-ALU drive/return, the flush control
// and the writeback handshake of int_alu_arbiter.
//   slave  : the arbiter's view
//   master : the environment's view (requesters, ALU, writeback consumer)
// ----------------------------------------------------------------------------
interface int_alu_arbiter_if #(
    parameter int TAG_W   = 6,
    parameter int NUM_REQ = 2
);
    // Requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][3:0]       req_alucode;
    logic [NUM_REQ-1:0][31:0]      req_op1;
    logic [NUM_REQ-1:0][31:0]      req_op2;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;

    // Shared combinational ALU
    logic [3:0]                    alu_code;
    logic [31:0]                   alu_op1;
    logic [31:0]                   alu_op2;
    logic [31:0]                   alu_result;

    // Control and writeback
    logic                          flush;
    logic                          res_valid;
    logic                          res_ready;
    logic [31:0]                   res_data;
    logic [TAG_W-1:0]              res_tag;
    logic                          res_src;

    modport slave (
        input  req_valid, req_alucode, req_op1, req_op2, req_tag,
        output req_ready,
        output alu_code, alu_op1, alu_op2,
        input  alu_result,
        input  flush,
        output res_valid,
        input  res_ready,
        output res_data, res_tag, res_src
    );

    modport master (
        output req_valid, req_alucode, req_op1, req_op2, req_tag,
        input  req_ready,
        input  alu_code, alu_op1, alu_op2,
        output alu_result,
        output flush,
        input  res_valid,
        output res_ready,
        input  res_data, res_tag, res_src
    );
endinterface

// File: rtl/int_alu_arbiter.sv
// ----------------------------------------------------------------------------
// int_alu_arbiter
// Two requesters share one combinational ALU. At most one op is granted per
// cycle; its result is captured into a one-entry output register (EMPTY/FULL
// FSM) and presented on a valid/ready writeback port one cycle later. A
// consumed result can be replaced in the same edge, sustaining 1 op/cycle.
//
// Build option:
//   ALU_ARB_ROUND_ROBIN_EN  defined   -> 1-bit round-robin pointer decides
//                                        simultaneous requests
//                           undefined -> fixed priority, requester 0 wins
// Reset is synchronous, active-low.
// ----------------------------------------------------------------------------
module int_alu_arbiter #(
    parameter int TAG_W   = 6,
    parameter int NUM_REQ = 2
) (
    input logic               clk,
    input logic               rst_n,
    int_alu_arbiter_if.slave  bus
);

    localparam logic [3:0] ALU_NONE = 4'h0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        res_data_q, res_data_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic               res_src_q, res_src_d;

    logic               can_accept;
    logic               win_any;
    logic               win_idx;
    logic               xfer;
    logic [NUM_REQ-1:0] ready;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic               prio_q, prio_d;
`endif

    // Reset is folded in so nothing is granted while rst_n is low.
    assign can_accept = rst_n && !bus.flush && (state_q == EMPTY || bus.res_ready);
    assign xfer       = can_accept && win_any;

    // Winner selection: the sole valid requester wins; a tie goes to the
    // pointer (round-robin build) or to requester 0 (fixed-priority build).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        win_any = 1'b0;
        win_idx = 1'b0;
        if (bus.req_valid[0] && bus.req_valid[1]) begin
            win_any = 1'b1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            win_idx = prio_q;
`else
            win_idx = 1'b0;
`endif
        end else if (bus.req_valid[1]) begin
            win_any = 1'b1;
            win_idx = 1'b1;
        end else if (bus.req_valid[0]) begin
            win_any = 1'b1;
            win_idx = 1'b0;
        end
    end

    // Grant and ALU drive: only the transferring winner is steered to the ALU.
    always_comb begin
        ready        = '0;
        bus.alu_code = ALU_NONE;
        bus.alu_op1  = '0;
        bus.alu_op2  = '0;
        if (xfer) begin
            ready[win_idx] = 1'b1;
            bus.alu_code   = bus.req_alucode[win_idx];
            bus.alu_op1    = bus.req_op1[win_idx];
            bus.alu_op2    = bus.req_op2[win_idx];
        end
    end

    assign bus.req_ready = ready;

    // Next state: load on transfer, otherwise empty on flush or on drain.
    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_tag_d  = res_tag_q;
        res_src_d  = res_src_q;
        if (xfer) begin
            state_d    = FULL;
            res_data_d = bus.alu_result;
            res_tag_d  = bus.req_tag[win_idx];
            res_src_d  = win_idx;
        end else if (bus.flush) begin
            state_d = EMPTY;
        end else if (state_q == FULL && bus.res_ready) begin
            state_d = EMPTY;
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Pointer moves to the requester that did not just win.
    always_comb begin
        prio_d = prio_q;
        if (xfer) begin
            prio_d = ~win_idx;
        end
    end
`endif

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= EMPTY;
            res_data_q <= '0;
            res_tag_q  <= '0;
            res_src_q  <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            prio_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_tag_q  <= res_tag_d;
            res_src_q  <= res_src_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            prio_q     <= prio_d;
`endif
        end
    end

    assign bus.res_valid = (state_q == FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_tag   = res_tag_q;
    assign bus.res_src   = res_src_q;

endmodule

// File: tb/tb_int_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_int_alu_arbiter
// Directed bench for int_alu_arbiter. Provides a small combinational ALU
// (NONE/ADD/SUB/AND) on the shared ALU port and steps through hand-computed
// vectors. Expected tie-break order follows ALU_ARB_ROUND_ROBIN_EN.
// ----------------------------------------------------------------------------
module tb_int_alu_arbiter;

    localparam int TAG_W = 6;

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam logic [3:0] TIE_SRC = 4'b1010;   // sources 0,1,0,1
`else
    localparam logic [3:0] TIE_SRC = 4'b0000;   // sources 0,0,0,0
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    int_alu_arbiter_if #(.TAG_W(TAG_W), .NUM_REQ(2)) bus ();

    int_alu_arbiter #(.TAG_W(TAG_W), .NUM_REQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU supplied by the environment.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_code)
            OP_ADD:  bus.alu_result = bus.alu_op1 + bus.alu_op2;
            OP_SUB:  bus.alu_result = bus.alu_op1 - bus.alu_op2;
            OP_AND:  bus.alu_result = bus.alu_op1 & bus.alu_op2;
            default: bus.alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] code,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t);
        bus.req_valid[i]   = v;
        bus.req_alucode[i] = code;
        bus.req_op1[i]     = a;
        bus.req_op2[i]     = b;
        bus.req_tag[i]     = t;
    endtask

    task automatic check_res(input string tag, input logic v, input logic [31:0] d,
                             input logic [TAG_W-1:0] t, input logic s);
        check({tag, ".valid"}, 32'(bus.res_valid), 32'(v));
        check({tag, ".data"},  bus.res_data, d);
        check({tag, ".tag"},   32'(bus.res_tag), 32'(t));
        check({tag, ".src"},   32'(bus.res_src), 32'(s));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // ---- Reset: requests present but nothing granted ----
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.res_ready = 1'b0;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1, 6'd1);
        set_req(1, 1'b1, OP_ADD, 32'd2, 32'd2, 6'd2);
        #1;
        check("rst.ready", 32'(bus.req_ready), 32'd0);
        tick();
        tick();
        check_res("rst", 1'b0, 32'd0, 6'd0, 1'b0);
        check("rst.ready2", 32'(bus.req_ready), 32'd0);

        // ---- Idle after release ----
        rst_n = 1'b1;
        set_req(0, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        set_req(1, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        #1;
        check("idle.alu_code", 32'(bus.alu_code), 32'(OP_NONE));
        check("idle.alu_op1", bus.alu_op1, 32'd0);
        tick();
        check("idle.valid", 32'(bus.res_valid), 32'd0);

        // ---- req0 only: ADD 5+7, tag 3 ----
        bus.res_ready = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7, 6'd3);
        #1;
        check("add.ready", 32'(bus.req_ready), 32'b01);
        check("add.alu_code", 32'(bus.alu_code), 32'(OP_ADD));
        tick();
        set_req(0, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        check_res("add", 1'b1, 32'd12, 6'd3, 1'b0);
        tick();
        check("drain.valid", 32'(bus.res_valid), 32'd0);

        // ---- req1 only: SUB 100-1, tag 5 ----
        set_req(1, 1'b1, OP_SUB, 32'd100, 32'd1, 6'd5);
        #1;
        check("sub.ready", 32'(bus.req_ready), 32'b10);
        tick();
        set_req(1, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        check_res("sub", 1'b1, 32'd99, 6'd5, 1'b1);
        tick();

        // ---- Both valid for 4 cycles ----
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1, 6'd10);
        set_req(1, 1'b1, OP_ADD, 32'd2, 32'd2, 6'd20);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("tie%0d.ready", k), 32'(bus.req_ready),
                  TIE_SRC[k] ? 32'b10 : 32'b01);
            tick();
            check_res($sformatf("tie%0d", k), 1'b1,
                      TIE_SRC[k] ? 32'd4 : 32'd2,
                      TIE_SRC[k] ? 6'd20 : 6'd10, TIE_SRC[k]);
        end
        set_req(0, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        set_req(1, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        tick();
        check("tie.drain", 32'(bus.res_valid), 32'd0);

        // ---- Stall: FULL with res_ready=0, req1 waiting ----
        bus.res_ready = 1'b0;
        set_req(0, 1'b1, OP_AND, 32'hF0F0_FFFF, 32'h0FF0_00FF, 6'd7);
        tick();
        set_req(0, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        set_req(1, 1'b1, OP_ADD, 32'd30, 32'd12, 6'd9);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d.ready", k), 32'(bus.req_ready), 32'd0);
            tick();
            check_res($sformatf("stall%0d", k), 1'b1, 32'h00F0_00FF, 6'd7, 1'b0);
        end
        bus.res_ready = 1'b1;
        #1;
        check("unstall.ready", 32'(bus.req_ready), 32'b10);
        tick();
        set_req(1, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        check_res("unstall", 1'b1, 32'd42, 6'd9, 1'b1);

        // ---- Flush while FULL with req0 valid ----
        bus.res_ready = 1'b0;
        bus.flush     = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2, 6'd1);
        #1;
        check("flush.ready", 32'(bus.req_ready), 32'd0);
        check("flush.alu_code", 32'(bus.alu_code), 32'(OP_NONE));
        tick();
        bus.flush = 1'b0;
        set_req(0, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        check("flush.valid", 32'(bus.res_valid), 32'd0);
        tick();
        check("flush.valid2", 32'(bus.res_valid), 32'd0);

        // ---- ALU_NONE passes through; then full-width result ----
        bus.res_ready = 1'b1;
        set_req(0, 1'b1, OP_NONE, 32'd55, 32'd66, 6'h2A);
        #1;
        check("none.alu_op1", bus.alu_op1, 32'd55);
        tick();
        set_req(0, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        check_res("none", 1'b1, 32'd0, 6'h2A, 1'b0);
        set_req(1, 1'b1, OP_ADD, 32'h8000_0000, 32'h7FFF_FFFF, 6'h3F);
        tick();
        set_req(1, 1'b0, OP_NONE, 32'd0, 32'd0, 6'd0);
        check_res("wide", 1'b1, 32'hFFFF_FFFF, 6'h3F, 1'b1);
        tick();

        // ---- Reset while FULL and stalled ----
        bus.res_ready = 1'b0;
        set_req(0, 1'b1, OP_ADD, 32'd3, 32'd4, 6'd4);
        tick();
        check_res("prerst", 1'b1, 32'd7, 6'd4, 1'b0);
        set_req(1, 1'b1, OP_ADD, 32'd8, 32'd8, 6'd8);
        rst_n = 1'b0;
        #1;
        check("midrst.ready", 32'(bus.req_ready), 32'd0);
        tick();
        check_res("midrst", 1'b0, 32'd0, 6'd0, 1'b0);
        rst_n         = 1'b1;
        bus.res_ready = 1'b1;
        #1;
        check("postrst.ready", 32'(bus.req_ready), 32'b01);
        tick();
        check_res("postrst", 1'b1, 32'd7, 6'd4, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
